// File: rtl/ysyx_23060191_wbu.sv
// ysyx_23060191_wbu: write-back unit retiring one EXU packet at a time and owning the machine CSRs
module ysyx_23060191_wbu #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter logic [CPU_WIDTH-1:0] MCAUSE_ECALL = 32'd11,
    parameter logic [CPU_WIDTH-1:0] MSTATUS_RST = 32'h1800
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [CPU_WIDTH-1:0]      i_pc,
    input  logic [CPU_WIDTH-1:0]      i_next_pc,
    input  logic [CPU_WIDTH-1:0]      i_exu_res,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic                      i_rd_wen,
    input  logic [CPU_WIDTH-1:0]      i_csr_res,
    input  logic                      i_csr_res_en,
    input  logic [11:0]               i_csr_waddr,
    input  logic                      i_is_ecall,
    input  logic                      i_is_mret,
    input  logic [11:0]               i_csr_raddr,
    output logic [CPU_WIDTH-1:0]      o_csr_rdata,
    output logic                      o_rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] o_rf_waddr,
    output logic [CPU_WIDTH-1:0]      o_rf_wdata,
    output logic                      o_commit,
    output logic [CPU_WIDTH-1:0]      o_commit_pc,
    output logic [CPU_WIDTH-1:0]      o_next_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {IDLE, WB, TRAP} state_t;

    state_t state, next_state;

    logic [CPU_WIDTH-1:0]      pc_q, next_pc_q, exu_res_q, csr_res_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      rd_wen_q, csr_res_en_q, ecall_q, mret_q;
    logic [11:0]               csr_waddr_q;
    logic [CPU_WIDTH-1:0]      mstatus, mtvec, mepc, mcause;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and strobes; strobes are masked during reset so an aborted packet never retires
    always_comb begin
        next_state  = IDLE;
        o_ready     = state == IDLE;
        o_rf_wen    = 1'b0;
        o_commit    = 1'b0;
        o_next_pc   = '0;
        o_rf_waddr  = rd_q;
        o_rf_wdata  = exu_res_q;
        o_commit_pc = pc_q;
        case (state)
            IDLE: begin
                next_state = i_valid ? WB : IDLE;
            end
            WB: begin
                next_state = ecall_q ? TRAP : IDLE;
                o_rf_wen   = !i_rst && rd_wen_q && rd_q != '0;
                o_commit   = !i_rst && !ecall_q;
                o_next_pc  = ecall_q ? '0 : mret_q ? mepc : next_pc_q;
            end
            TRAP: begin
                o_commit  = !i_rst;
                o_next_pc = mtvec;
            end
            default: next_state = IDLE;
        endcase
    end

    // Packet latch, only loaded on an IDLE handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q         <= '0;
            next_pc_q    <= '0;
            exu_res_q    <= '0;
            csr_res_q    <= '0;
            rd_q         <= '0;
            rd_wen_q     <= 1'b0;
            csr_res_en_q <= 1'b0;
            csr_waddr_q  <= '0;
            ecall_q      <= 1'b0;
            mret_q       <= 1'b0;
        end else if (state == IDLE && i_valid) begin
            pc_q         <= i_pc;
            next_pc_q    <= i_next_pc;
            exu_res_q    <= i_exu_res;
            csr_res_q    <= i_csr_res;
            rd_q         <= i_rd;
            rd_wen_q     <= i_rd_wen;
            csr_res_en_q <= i_csr_res_en;
            csr_waddr_q  <= i_csr_waddr;
            ecall_q      <= i_is_ecall;
            mret_q       <= i_is_mret;
        end
    end

    // CSR updates: ECALL beats MRET beats plain CSR write; trap entry finishes in TRAP
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus <= MSTATUS_RST;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (state == WB) begin
            if (ecall_q) begin
                mepc <= csr_res_q;
            end else if (mret_q) begin
                mstatus[3] <= mstatus[7];
                mstatus[7] <= 1'b1;
            end else if (csr_res_en_q) begin
                case (csr_waddr_q)
                    CSR_MSTATUS: mstatus <= csr_res_q;
                    CSR_MTVEC:   mtvec   <= csr_res_q;
                    CSR_MEPC:    mepc    <= csr_res_q;
                    CSR_MCAUSE:  mcause  <= csr_res_q;
                    default: ;
                endcase
            end
        end else if (state == TRAP) begin
            mcause     <= MCAUSE_ECALL;
            mstatus[7] <= mstatus[3];
            mstatus[3] <= 1'b0;
        end
    end

    // Register-only CSR read; one packet in flight makes forwarding unnecessary
    always_comb begin
        o_csr_rdata = i_csr_raddr == CSR_MSTATUS ? mstatus :
                      i_csr_raddr == CSR_MTVEC   ? mtvec   :
                      i_csr_raddr == CSR_MEPC    ? mepc    :
                      i_csr_raddr == CSR_MCAUSE  ? mcause  : '0;
    end

endmodule

// File: tb/tb_ysyx_23060191_wbu.sv
// tb_ysyx_23060191_wbu: randomized self-checking bench for the write-back unit against a transaction-level CSR model
module tb_ysyx_23060191_wbu;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, o_ready;
    logic [31:0] i_pc, i_next_pc, i_exu_res, i_csr_res;
    logic [4:0]  i_rd;
    logic        i_rd_wen, i_csr_res_en, i_is_ecall, i_is_mret;
    logic [11:0] i_csr_waddr, i_csr_raddr;
    logic [31:0] o_csr_rdata, o_rf_wdata, o_commit_pc, o_next_pc;
    logic        o_rf_wen, o_commit;
    logic [4:0]  o_rf_waddr;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    always #10 clk = ~clk;

    ysyx_23060191_wbu dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_next_pc(i_next_pc), .i_exu_res(i_exu_res), .i_rd(i_rd),
        .i_rd_wen(i_rd_wen), .i_csr_res(i_csr_res), .i_csr_res_en(i_csr_res_en),
        .i_csr_waddr(i_csr_waddr), .i_is_ecall(i_is_ecall), .i_is_mret(i_is_mret),
        .i_csr_raddr(i_csr_raddr), .o_csr_rdata(o_csr_rdata), .o_rf_wen(o_rf_wen),
        .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata), .o_commit(o_commit),
        .o_commit_pc(o_commit_pc), .o_next_pc(o_next_pc)
    );

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mstatus = 32'h1800;
        m_mtvec   = 32'h0;
        m_mepc    = 32'h0;
        m_mcause  = 32'h0;
    endtask

    task automatic scramble();
        i_pc         = $urandom;
        i_next_pc    = $urandom;
        i_exu_res    = $urandom;
        i_rd         = 5'($urandom);
        i_rd_wen     = 1'($urandom);
        i_csr_res    = $urandom;
        i_csr_res_en = 1'($urandom);
        i_csr_waddr  = 12'h305;
        i_is_ecall   = 1'($urandom);
        i_is_mret    = 1'($urandom);
    endtask

    task automatic check_csrs(input string tag);
        logic [11:0] a [5];
        a = '{12'h300, 12'h305, 12'h341, 12'h342, 12'($urandom_range(0, 4095))};
        for (int k = 0; k < 5; k++) begin
            i_csr_raddr = a[k];
            #1;
            checks++;
            if (o_csr_rdata !== m_read(a[k])) begin
                failures++;
                $display("FAIL %s csr[%h] got=%h exp=%h", tag, a[k], o_csr_rdata, m_read(a[k]));
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic do_pkt(input logic [31:0] pc, npc, res, input logic [4:0] rd, input logic rd_wen,
                          input logic [31:0] cres, input logic cen, input logic [11:0] caddr,
                          input logic ec, mr);
        logic        exp_wen;
        logic [31:0] exp_next;
        exp_wen = rd_wen && rd != 5'd0;
        if (ec) begin
            exp_next  = m_mtvec;
            m_mepc    = cres;
            m_mcause  = 32'd11;
            m_mstatus = {m_mstatus[31:8], m_mstatus[3], m_mstatus[6:4], 1'b0, m_mstatus[2:0]};
        end else if (mr) begin
            exp_next  = m_mepc;
            m_mstatus = {m_mstatus[31:8], 1'b1, m_mstatus[6:4], m_mstatus[7], m_mstatus[2:0]};
        end else begin
            exp_next = npc;
            if (cen && caddr == 12'h300) m_mstatus = cres;
            if (cen && caddr == 12'h305) m_mtvec = cres;
            if (cen && caddr == 12'h341) m_mepc = cres;
            if (cen && caddr == 12'h342) m_mcause = cres;
        end
        i_pc = pc; i_next_pc = npc; i_exu_res = res; i_rd = rd; i_rd_wen = rd_wen;
        i_csr_res = cres; i_csr_res_en = cen; i_csr_waddr = caddr; i_is_ecall = ec; i_is_mret = mr;
        i_valid = 1'b1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL ready_idle got=%b exp=1", o_ready); end
        @(negedge clk);
        scramble();
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL ready_wb got=%b exp=0", o_ready); end
        checks++; if (o_rf_wen !== exp_wen) begin failures++; $display("FAIL rf_wen got=%b exp=%b", o_rf_wen, exp_wen); end
        if (exp_wen) begin
            checks++; if (o_rf_waddr !== rd) begin failures++; $display("FAIL rf_waddr got=%0d exp=%0d", o_rf_waddr, rd); end
            checks++; if (o_rf_wdata !== res) begin failures++; $display("FAIL rf_wdata got=%h exp=%h", o_rf_wdata, res); end
        end
        checks++; if (o_commit !== !ec) begin failures++; $display("FAIL commit_wb got=%b exp=%b", o_commit, !ec); end
        if (!ec) begin
            checks++; if (o_next_pc !== exp_next) begin failures++; $display("FAIL next_pc got=%h exp=%h", o_next_pc, exp_next); end
            checks++; if (o_commit_pc !== pc) begin failures++; $display("FAIL commit_pc got=%h exp=%h", o_commit_pc, pc); end
        end else begin
            @(negedge clk);
            scramble();
            checks++; if (o_commit !== 1'b1) begin failures++; $display("FAIL commit_trap got=%b exp=1", o_commit); end
            checks++; if (o_rf_wen !== 1'b0) begin failures++; $display("FAIL rf_wen_trap got=%b exp=0", o_rf_wen); end
            checks++; if (o_next_pc !== exp_next) begin failures++; $display("FAIL trap_next_pc got=%h exp=%h", o_next_pc, exp_next); end
            checks++; if (o_commit_pc !== pc) begin failures++; $display("FAIL trap_commit_pc got=%h exp=%h", o_commit_pc, pc); end
            i_csr_raddr = 12'h341;
            #1;
            checks++; if (o_csr_rdata !== m_mepc) begin failures++; $display("FAIL mepc_in_trap got=%h exp=%h", o_csr_rdata, m_mepc); end
        end
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL ready_after got=%b exp=1", o_ready); end
        checks++; if (o_commit !== 1'b0) begin failures++; $display("FAIL commit_idle got=%b exp=0", o_commit); end
        checks++; if (o_rf_wen !== 1'b0) begin failures++; $display("FAIL rf_wen_idle got=%b exp=0", o_rf_wen); end
        check_csrs("after_pkt");
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_csr_raddr = 12'h0;
        scramble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_commit !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b exp=0", o_commit); end
        checks++; if (o_rf_wen !== 1'b0) begin failures++; $display("FAIL reset_rf_wen got=%b exp=0", o_rf_wen); end
        checks++; if (o_next_pc !== 32'h0) begin failures++; $display("FAIL reset_next_pc got=%h exp=0", o_next_pc); end
        checks++; if (o_commit_pc !== 32'h0) begin failures++; $display("FAIL reset_commit_pc got=%h exp=0", o_commit_pc); end
        i_csr_raddr = 12'h300;
        #1;
        checks++; if (o_csr_rdata !== 32'h1800) begin failures++; $display("FAIL reset_mstatus got=%h exp=1800", o_csr_rdata); end
        check_csrs("reset");
        i_rst = 1'b0;
    endtask

    task automatic test_add();
        do_pkt(32'h80000000, 32'h80000004, 32'h1234, 5'd5, 1'b1, 32'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    endtask

    task automatic test_x0();
        do_pkt(32'h80000004, 32'h80000008, 32'hdeadbeef, 5'd0, 1'b1, 32'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    endtask

    task automatic test_csrrw_mtvec();
        do_pkt(32'h80000008, 32'h8000000c, 32'h0, 5'd3, 1'b1, 32'h80000100, 1'b1, 12'h305, 1'b0, 1'b0);
        i_csr_raddr = 12'h305;
        #1;
        checks++; if (o_csr_rdata !== 32'h80000100) begin failures++; $display("FAIL mtvec_const got=%h exp=80000100", o_csr_rdata); end
        do_pkt(32'h8000000c, 32'h80000010, 32'h55, 5'd7, 1'b1, 32'hffffffff, 1'b1, 12'h7c0, 1'b0, 1'b0);
    endtask

    task automatic test_ecall();
        do_pkt(32'h80000010, 32'h80000014, 32'h0, 5'd0, 1'b0, 32'h1808, 1'b1, 12'h300, 1'b0, 1'b0);
        do_pkt(32'h80000040, 32'h80000044, 32'h0, 5'd0, 1'b0, 32'h80000040, 1'b1, 12'h305, 1'b1, 1'b0);
        i_csr_raddr = 12'h342;
        #1;
        checks++; if (o_csr_rdata !== 32'd11) begin failures++; $display("FAIL ecall_mcause got=%h exp=b", o_csr_rdata); end
        i_csr_raddr = 12'h300;
        #1;
        checks++; if (o_csr_rdata !== 32'h1880) begin failures++; $display("FAIL ecall_mstatus got=%h exp=1880", o_csr_rdata); end
    endtask

    task automatic test_mret();
        do_pkt(32'h80000200, 32'h80000204, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b0, 1'b1);
        i_csr_raddr = 12'h300;
        #1;
        checks++; if (o_csr_rdata !== 32'h1888) begin failures++; $display("FAIL mret_mstatus got=%h exp=1888", o_csr_rdata); end
    endtask

    task automatic test_ecall_mret_both();
        do_pkt(32'h80000300, 32'h80000304, 32'h9, 5'd9, 1'b1, 32'h80000300, 1'b1, 12'h305, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [11:0] addrs [5];
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [31:0] pc;
            addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'($urandom_range(0, 4095))};
            r = $urandom_range(0, 9);
            pc = $urandom & 32'hfffffffc;
            do_pkt(pc, pc + 32'd4, $urandom, 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
                   addrs[$urandom_range(0, 4)], r == 0 || r == 2, r == 1 || r == 2);
        end
    endtask

    task automatic test_reset_trap();
        do_pkt(32'h80000000, 32'h80000004, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 12'h305, 1'b0, 1'b0);
        i_pc = 32'h80000080; i_next_pc = 32'h80000084; i_exu_res = 32'h1; i_rd = 5'd4; i_rd_wen = 1'b1;
        i_csr_res = 32'h80000080; i_csr_res_en = 1'b0; i_csr_waddr = 12'h0; i_is_ecall = 1'b1; i_is_mret = 1'b0;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (o_commit !== 1'b0) begin failures++; $display("FAIL rt_commit_wb got=%b exp=0", o_commit); end
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        checks++; if (o_commit !== 1'b0) begin failures++; $display("FAIL rt_commit_trap got=%b exp=0", o_commit); end
        @(negedge clk);
        m_reset();
        i_rst = 1'b0;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rt_ready got=%b exp=1", o_ready); end
        checks++; if (o_commit !== 1'b0) begin failures++; $display("FAIL rt_commit_after got=%b exp=0", o_commit); end
        i_csr_raddr = 12'h342;
        #1;
        checks++; if (o_csr_rdata !== 32'h0) begin failures++; $display("FAIL rt_mcause got=%h exp=0", o_csr_rdata); end
        check_csrs("reset_trap");
        @(negedge clk);
        checks++; if (o_commit !== 1'b0) begin failures++; $display("FAIL rt_commit_late got=%b exp=0", o_commit); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_x0();
        test_csrrw_mtvec();
        test_ecall();
        test_mret();
        test_ecall_mret_both();
        test_random();
        test_reset_trap();
        test_add();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_wbu.md
Name: ysyx_23060191_wbu

Overview:
Write-back unit: the receiving end of the EXU result interface in the multi-cycle RV32 core.
- Accepts one EXU result packet through a valid/ready handshake.
- Writes the GPR file and the machine CSR file.
- Sequences ECALL/MRET trap state.
- Emits a commit pulse carrying the next PC to the IFU.
- Owns the CSRs and supplies the combinational CSR read data that the EXU consumes as i_data_rd_csr.

Parameters:
CPU_WIDTH, 32, datapath width
REG_ADDR_WIDTH, 5, GPR index width
MCAUSE_ECALL, 32'd11, mcause value written on ECALL from M-mode
MSTATUS_RST, 32'h1800, mstatus reset value (MPP=M)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  EXU packet valid
o_ready  out  1  WBU can accept packet
i_pc  in  CPU_WIDTH  PC of the instruction
i_next_pc  in  CPU_WIDTH  sequential/branch next PC computed upstream
i_exu_res  in  CPU_WIDTH  GPR write data
i_rd  in  REG_ADDR_WIDTH  GPR destination
i_rd_wen  in  1  GPR write requested
i_csr_res  in  CPU_WIDTH  CSR write data (equals PC for ECALL)
i_csr_res_en  in  1  CSR write requested
i_csr_waddr  in  12  CSR write address
i_is_ecall  in  1  instruction is ECALL
i_is_mret  in  1  instruction is MRET
i_csr_raddr  in  12  CSR read address from EXU
o_csr_rdata  out  CPU_WIDTH  CSR read data (combinational)
o_rf_wen  out  1  GPR write strobe
o_rf_waddr  out  REG_ADDR_WIDTH  GPR write index
o_rf_wdata  out  CPU_WIDTH  GPR write data
o_commit  out  1  one-cycle instruction-retired pulse
o_commit_pc  out  CPU_WIDTH  PC of the retired instruction
o_next_pc  out  CPU_WIDTH  PC the IFU fetches next

Behaviour:
- Reset: state=IDLE; o_ready=1 (driven from state); o_rf_wen=0, o_commit=0; o_rf_waddr, o_rf_wdata, o_commit_pc, o_next_pc=0.
- Reset CSR values: mstatus=MSTATUS_RST; mtvec, mepc, mcause=0.
- Reset mid-operation aborts the packet: no write, no commit.
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
  - Reads of any other address return 0; writes to any other address are ignored.
  - o_csr_rdata reflects register contents only, with no forwarding. This is safe because only one packet is in flight.
- FSM has three states: IDLE, WB, TRAP.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready, latch all input fields and go to WB.
  - No input is sampled outside IDLE.
- WB (exactly one cycle):
  - o_rf_wen=latched rd_wen && rd!=0. x0 writes are suppressed. waddr/wdata come from the latch.
  - If is_ecall:
    - mepc<=csr_res.
    - The CSR write request is dropped (ECALL has priority).
    - No commit this cycle; next state TRAP.
  - Else if is_mret:
    - mstatus.MIE(bit3)<=MPIE(bit7); MPIE<=1.
    - o_commit=1, o_next_pc=mepc (value before this cycle's writes).
    - Next state IDLE.
  - Else:
    - If csr_res_en, write csr_res to csr_waddr.
    - o_commit=1, o_next_pc=latched next_pc.
    - Next state IDLE.
  - is_ecall && is_mret together is treated as ECALL.
- TRAP (one cycle):
  - mcause<=MCAUSE_ECALL.
  - mstatus.MPIE<=MIE; MIE<=0.
  - o_commit=1, o_next_pc=mtvec, o_commit_pc=latched pc.
  - Next state IDLE.
- Latency and throughput:
  - Accept at cycle N → write and commit at N+1 (normal/MRET) or N+2 (ECALL).
  - Throughput is one packet per 2 cycles (3 for ECALL).
- Strobe rules:
  - o_commit and o_rf_wen are registered-state-derived single-cycle pulses, never asserted in IDLE.
  - A CSR write to mepc/mtvec becomes visible on o_csr_rdata in the cycle after WB.

Test Plan:
- Reset → o_ready=1, o_commit=0, o_csr_rdata@0x300=0x1800, @0x305/0x341/0x342=0.
- ADD packet (rd=5, exu_res=0x1234, next_pc=0x80000004) → at N+1: o_rf_wen=1, waddr=5, wdata=0x1234, o_commit=1, o_next_pc=0x80000004; o_ready=0 at N+1, 1 at N+2.
- rd=0, rd_wen=1 → o_rf_wen=0, commit still pulses.
- CSRRW to mtvec data 0x80000100 (also rd=3, exu_res=old 0) → mtvec reads 0x80000100 next cycle; rf writes x3=0.
- ECALL at pc=0x80000040, mstatus=0x1808 → N+1: mepc=0x80000040, no commit; N+2: mcause=11, mstatus=0x1880, o_commit=1, o_next_pc=mtvec.
- MRET afterwards → o_next_pc=0x80000040, mstatus=0x1888.
- Reset asserted during TRAP → no commit; mcause=0; state IDLE.
